// File: rtl/csa_slice_sequencer.sv
// csa_slice_sequencer: WIDTH-bit adder that reuses one 2-bit carry-select slice,
// producing two result bits per cycle behind valid/ready handshakes.
module csa_slice_sequencer #(
    parameter int WIDTH = 16,
    localparam int NSLICE = WIDTH / 2,
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [IW-1:0]    slice_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic carry_q, carry_d, cout_q, cout_d, busy_q, busy_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW:0] base;
    logic [1:0] pa, pb;
    logic [2:0] cand0, cand1, sel;
    logic last;
    always_comb begin
        base = {idx_q, 1'b0};
        pa = a_q[base +: 2];
        pb = b_q[base +: 2];
        // both carry-in candidates are formed every cycle; the running carry picks one
        cand0 = {1'b0, pa} + {1'b0, pb};
        cand1 = cand0 + 3'd1;
        sel = carry_q ? cand1 : cand0;
        last = idx_q == IW'(NSLICE - 1);
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        carry_d = carry_q;
        cout_d = cout_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d = a;
                b_d = b;
                carry_d = cin;
                sum_d = '0;
                idx_d = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[base +: 2] = sel[1:0];
                carry_d = sel[2];
                idx_d = last ? '0 : idx_q + 1'b1;
                if (last) begin
                    cout_d = sel[2];
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            busy_q <= busy_d;
            idx_q <= idx_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign slice_idx = idx_q;
endmodule
